// File: rtl/edge_line_setup_pkg.sv
// Shared constants, types and edge topology for the per-frame edge-function setup block.
// Beam-position constants are 10 bits wide to match the x/y beam counters.
package edge_line_setup_pkg;

  localparam int EDGE_W    = 20;
  localparam int NUM_EDGES = 6;
  localparam int NUM_VERTS = 4;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] SETUP_Y   = 10'd480;
  localparam logic [9:0] STEP_X    = 10'd700;
  localparam logic [9:0] V_LAST    = 10'd524;
  localparam logic [9:0] H_LAST    = 10'd799;

  localparam logic [3:0] MUL_LAST  = 4'd11;

  typedef logic signed [EDGE_W-1:0]   coord_t;
  typedef logic signed [2*EDGE_W-1:0] prod_t;
  typedef logic signed [2*EDGE_W:0]   sum_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Edges 0..2 belong to triangle t1 (v0,v1,v2), edges 3..5 to t2 (v0,v2,v3).
  function automatic logic [1:0] edge_va(input logic [2:0] e);
    case (e)
      3'd0:    return 2'd0;
      3'd1:    return 2'd1;
      3'd2:    return 2'd2;
      3'd3:    return 2'd0;
      3'd4:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] edge_vb(input logic [2:0] e);
    case (e)
      3'd0:    return 2'd1;
      3'd1:    return 2'd2;
      3'd2:    return 2'd0;
      3'd3:    return 2'd2;
      3'd4:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/edge_line_setup_mul.sv
// Registered 20x20 signed multiplier with a single cycle of latency.
// Shared by all twelve coefficient products of a frame setup.
module mul_s20
  import edge_line_setup_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [EDGE_W-1:0]   a,
  input  logic signed [EDGE_W-1:0]   b,
  output logic signed [2*EDGE_W-1:0] p
);

  always_ff @(posedge clk) begin
    if (reset) begin
      p <= '0;
    end else begin
      p <= a * b;
    end
  end

endmodule

// File: rtl/edge_line_setup.sv
// Per-frame edge-function setup for two triangles of a quad, plus per-line stepping
// of the x=0 edge values during the visible raster.
module edge_line_setup
  import edge_line_setup_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               x,
  input  logic [9:0]               y,
  input  logic signed [EDGE_W-1:0] x_screen_v0,
  input  logic signed [EDGE_W-1:0] x_screen_v1,
  input  logic signed [EDGE_W-1:0] x_screen_v2,
  input  logic signed [EDGE_W-1:0] x_screen_v3,
  input  logic signed [EDGE_W-1:0] y_screen_v0,
  input  logic signed [EDGE_W-1:0] y_screen_v1,
  input  logic signed [EDGE_W-1:0] y_screen_v2,
  input  logic signed [EDGE_W-1:0] y_screen_v3,
  output logic signed [EDGE_W-1:0] e0_init_t1,
  output logic signed [EDGE_W-1:0] e1_init_t1,
  output logic signed [EDGE_W-1:0] e2_init_t1,
  output logic signed [EDGE_W-1:0] e0_init_t2,
  output logic signed [EDGE_W-1:0] e1_init_t2,
  output logic signed [EDGE_W-1:0] e2_init_t2,
  output logic                     setup_busy,
  output logic                     frame_ready
);

  localparam logic [9:0] LAST_STEP_Y = V_VISIBLE - 10'd2;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] k;

  coord_t vin_x [NUM_VERTS];
  coord_t vin_y [NUM_VERTS];
  coord_t vx_q  [NUM_VERTS];
  coord_t vy_q  [NUM_VERTS];
  coord_t dx_q  [NUM_EDGES];
  coord_t dy_q  [NUM_EDGES];
  coord_t b_q   [NUM_EDGES];
  coord_t c_q   [NUM_EDGES];
  coord_t out_q [NUM_EDGES];

  coord_t     mul_a;
  coord_t     mul_b;
  prod_t      prod;
  sum_t       acc_q;
  sum_t       wb_sum;
  logic       wb_vld;
  logic [3:0] wb_k;
  logic [2:0] mul_edge;

  logic beam_valid;
  logic trigger;
  logic line_step;

  assign vin_x[0] = x_screen_v0;
  assign vin_x[1] = x_screen_v1;
  assign vin_x[2] = x_screen_v2;
  assign vin_x[3] = x_screen_v3;
  assign vin_y[0] = y_screen_v0;
  assign vin_y[1] = y_screen_v1;
  assign vin_y[2] = y_screen_v2;
  assign vin_y[3] = y_screen_v3;

  // A trigger is only honoured from IDLE, so a repeat during setup is dropped.
  assign beam_valid = (x <= H_LAST) && (y <= V_LAST);
  assign trigger    = (state == IDLE) && beam_valid && (y == SETUP_Y) && (x == 10'd0);
  assign line_step  = (state == IDLE) && beam_valid && (x >= H_VISIBLE) &&
                      (x == STEP_X) && (y <= LAST_STEP_Y);

  assign setup_busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = MUL;
      MUL:     if (k == MUL_LAST) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Even k issues xa*dY, odd k issues ya*dX; results land one cycle later.
  assign mul_edge = k[3:1];

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (k[0] == 1'b0) begin
      mul_a = vx_q[edge_va(mul_edge)];
      mul_b = dy_q[mul_edge];
    end else begin
      mul_a = vy_q[edge_va(mul_edge)];
      mul_b = dx_q[mul_edge];
    end
  end

  mul_s20 u_mul (
    .clk   (clk),
    .reset (reset),
    .a     (mul_a),
    .b     (mul_b),
    .p     (prod)
  );

  assign wb_sum = acc_q + sum_t'(prod);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      k           <= '0;
      wb_vld      <= 1'b0;
      wb_k        <= '0;
      acc_q       <= '0;
      frame_ready <= 1'b0;
      for (int i = 0; i < NUM_VERTS; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
      for (int i = 0; i < NUM_EDGES; i++) begin
        dx_q[i]  <= '0;
        dy_q[i]  <= '0;
        b_q[i]   <= '0;
        c_q[i]   <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state       <= state_nxt;
      frame_ready <= (state == COMMIT);
      wb_vld      <= (state == MUL);
      wb_k        <= k;

      if (state == MUL) begin
        k <= (k == MUL_LAST) ? 4'd0 : k + 4'd1;
      end else begin
        k <= '0;
      end

      if (trigger) begin
        for (int i = 0; i < NUM_VERTS; i++) begin
          vx_q[i] <= vin_x[i];
          vy_q[i] <= vin_y[i];
        end
        for (int i = 0; i < NUM_EDGES; i++) begin
          dx_q[i] <= vin_x[edge_vb(3'(i))] - vin_x[edge_va(3'(i))];
          dy_q[i] <= vin_y[edge_vb(3'(i))] - vin_y[edge_va(3'(i))];
          b_q[i]  <= vin_x[edge_va(3'(i))] - vin_x[edge_vb(3'(i))];
        end
      end

      if (wb_vld) begin
        if (wb_k[0] == 1'b0) begin
          acc_q <= -sum_t'(prod);
        end else begin
          c_q[wb_k[3:1]] <= wb_sum[EDGE_W-1:0];
        end
      end

      // The last edge's C is still in write-back during COMMIT, so forward it.
      if (state == COMMIT) begin
        for (int i = 0; i < NUM_EDGES; i++) begin
          out_q[i] <= (i == NUM_EDGES - 1) ? wb_sum[EDGE_W-1:0] : c_q[i];
        end
      end else if (line_step) begin
        for (int i = 0; i < NUM_EDGES; i++) begin
          out_q[i] <= out_q[i] + b_q[i];
        end
      end
    end
  end

  assign e0_init_t1 = out_q[0];
  assign e1_init_t1 = out_q[1];
  assign e2_init_t1 = out_q[2];
  assign e0_init_t2 = out_q[3];
  assign e1_init_t2 = out_q[4];
  assign e2_init_t2 = out_q[5];

endmodule

// File: doc/edge_line_setup.md
EDGE_LINE_SETUP -- requirements
Module: edge_line_setup

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (pixel-rate domain); single clock.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: x, y  in  10 each  VGA beam counters (x 0..799, y 0..524).
REQ-004 SHALL have ports: x_screen_v0..v3, y_screen_v0..v3  in  signed 20 each  screen-space vertex coordinates for the current quad.
REQ-005 SHALL have ports: e0_init_t1, e1_init_t1, e2_init_t1, e0_init_t2, e1_init_t2, e2_init_t2  out  signed 20 each  edge-function value at x=0 for the next raster line.
REQ-006 SHALL have ports: setup_busy  out  1  high while per-frame coefficient setup runs.
REQ-007 SHALL have ports: frame_ready  out  1  one-cycle pulse when new coefficients are committed.

Function
REQ-008 Edge k runs from va to vb. Triangle t1 edges are (v0->v1), (v1->v2), (v2->v0). Triangle t2 edges are (v0->v2), (v2->v3), (v3->v0).
REQ-009 Per edge: dX = xb-xa and dY = yb-ya, 20-bit two's-complement wrap. Step B = xa-xb. Constant C = ya*dX - xa*dY.
REQ-010 Products SHALL be full 40-bit signed. Sums SHALL be 41-bit. C SHALL be truncated to the low 20 bits (wrap, no saturation).
REQ-011 The FSM SHALL have three states: IDLE, MUL, COMMIT.
REQ-012 IDLE->MUL SHALL occur on the cycle with y==480 and x==0. On that same cycle the module SHALL latch all 8 vertex inputs and compute the six dX/dY/B values. Vertex inputs are ignored at all other times.
REQ-013 MUL SHALL use one shared registered signed multiplier for 12 cycles, counter k=0..11. Even k: acc = -(xa*dY) for edge k/2. Odd k: C[k/2] = acc + ya*dX.
REQ-014 MUL->COMMIT SHALL occur after k==11.
REQ-015 In COMMIT the module SHALL load all six outputs with their C values (the line-0 value), pulse frame_ready for 1 cycle, and return to IDLE.
REQ-016 Trigger-to-commit latency SHALL be 14 cycles. setup_busy SHALL be high from the cycle after the trigger through COMMIT inclusive.
REQ-017 Line stepping: on cycles with x==700 and y<=478, each output SHALL be replaced by output+B (20-bit wrap). The output then holds the line y+1 value before x==799.
REQ-018 No line step SHALL occur for y>=479. Outputs SHALL hold the line-0 values through y==524 and x==799.
REQ-019 A trigger arriving while setup_busy is high SHALL be ignored. A line step cannot coincide with setup because of REQ-012 and REQ-018, and none SHALL be applied if it did.
REQ-020 Outputs SHALL change only in COMMIT or on a line-step cycle.

Reset
REQ-021 While reset is high: state=IDLE, k=0, all six outputs=0, setup_busy=0, frame_ready=0, latched vertices/C/B=0.
REQ-022 Reset asserted mid-MUL SHALL abort the setup with no commit. The next setup starts only at the next y==480, x==0.

Structure
REQ-023 The shared package SHALL hold: EDGE_W=20, H_VISIBLE=640, V_VISIBLE=480, SETUP_Y=480, STEP_X=700, V_LAST=524, H_LAST=799, and the FSM state enum.
REQ-024 A single sub-module, mul_s20 (registered 20x20 signed multiply, 1-cycle latency), SHALL be instantiated once.
REQ-025 No other sub-modules.

Verification
REQ-026 Vertices v0=(100,100), v1=(200,100), v2=(100,200), v3=(200,200); run to frame_ready -> e0_init_t1=10000, e1_init_t1=-30000. Exactly 14 cycles after the trigger.
REQ-027 Same vertices, stepping -> e0_init_t1 = 10000-100*(y+1) after x==700 of line y; equals 9500 after line 4. e1_init_t1 steps +100 per line.
REQ-028 Change vertex inputs mid-frame (y==200) -> outputs keep stepping from the old coefficients; new values appear only after the next y==480 commit.
REQ-029 Assert reset at k==6 -> outputs=0, frame_ready never pulses; the next frame commits correct values.
REQ-030 Vertices (-524287,524287), (524287,-524287), ... -> C matches a 40-bit reference model truncated to 20 bits (wrap) for all six edges.
REQ-031 Check y==479..524 -> no output change from line 479 onward until the next commit. setup_busy is high for exactly 13 cycles per frame.
